// File: rtl/dec_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with enable.
// Direct mode decodes a handshaked select; scan mode sweeps every line, DWELL cycles each.
module dec_scan_nto2n #(
    parameter int unsigned N          = 3,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUTW      = 2**N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic            sel_valid,
    input  logic [N-1:0]    sel,
    output logic            sel_ready,
    output logic [OUTW-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [OUTW-1:0] Y_IDLE = {OUTW{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic                wrap_q, wrap_d;
    logic [OUTW-1:0]     y_q, y_d;
    logic                dwell_last_c;

    // Polarity is folded in here so y leaves the register already in its final sense.
    function automatic logic [OUTW-1:0] decode(input logic [N-1:0] i);
        return Y_IDLE ^ (OUTW'(1) << i);
    endfunction

    assign sel_ready    = (state_q == ST_DIRECT) & en & ~mode;
    assign dwell_last_c = (dwell_q == CNT_W'(DWELL - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = '0;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else if (mode) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end

        if (sel_ready && sel_valid) begin
            idx_d = sel;
        end

        // Dwell only runs while already scanning, so any entry into scan starts a full dwell.
        if ((state_q == ST_SCAN) && en && mode) begin
            if (dwell_last_c) begin
                idx_d  = idx_q + N'(1);
                wrap_d = &idx_q;
            end else begin
                dwell_d = dwell_q + CNT_W'(1);
            end
        end

        y_d = (state_d == ST_IDLE) ? Y_IDLE : decode(idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            y_q     <= Y_IDLE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
